// File: rtl/q2_word.sv
// rtl/q2_word.sv - W-bit Q2 word slice: A/X/P/S registers, dbus/abus drivers, conflict flag
// Optional hardware return stack built when Q2_PSTACK_EN is defined.
module q2_word #(
  parameter int W           = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic         incp_clk,
  input  logic         rst,
  input  logic [W-1:0] sw,
  input  logic         dep,
  inout  wire  [W-1:0] dbus,
  inout  wire  [W-1:0] abus,
  input  logic         wra,
  input  logic         rda,
  input  logic [W-1:0] ain,
  input  logic         wrx,
  input  logic         rdx,
  input  logic [3:0]   xin_sel,
  input  logic         xshift_in,
  input  logic         incp,
  input  logic         wrp,
  input  logic         rdp,
  input  logic         wrs,
  input  logic [W-1:0] sin,
  input  logic         call,
  input  logic         ret,
  output logic [W-1:0] aout,
  output logic [W-1:0] xout,
  output logic [W-1:0] pout,
  output logic [W-1:0] sout,
  output logic         xshift_out,
  output logic         pcarry,
  output logic         bus_err,
  output logic         stk_ovf
);

  logic [W-1:0] a_q, a_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] p_q, p_d;
  logic [W-1:0] s_q, s_d;
  logic         pcarry_q, pcarry_d;
  logic         bus_err_q, bus_err_d;

  logic         pop;
  logic [W-1:0] stk_top;

  // Deposit wins dbus, X wins abus; the losing source is simply never enabled.
  assign dbus = (!rst && dep) ? sw  :
                (!rst && rda) ? a_q : {W{1'bz}};
  assign abus = (!rst && rdx) ? x_q :
                (!rst && rdp) ? p_q : {W{1'bz}};

  always_comb begin
    a_d = a_q;
    if (wra) a_d = ain;
  end

  always_comb begin
    x_d = x_q;
    if (wrx) begin
      case (xin_sel)
        4'b1000: x_d = '0;
        4'b0100: x_d = {x_q[W-2:0], xshift_in};
        4'b0010: x_d = p_q;
        4'b0001: x_d = dbus;
        default: x_d = '1;
      endcase
    end
  end

  always_comb begin
    p_d      = p_q;
    pcarry_d = pcarry_q;
    if (wrp) begin
      p_d      = x_q;
      pcarry_d = 1'b0;
    end else if (pop) begin
      p_d = stk_top;
    end else if (incp) begin
      p_d      = p_q + 1'b1;
      pcarry_d = &p_q;
    end
  end

  always_comb begin
    s_d = s_q;
    if (wrs) s_d = sin;
  end

  assign bus_err_d = bus_err_q | (dep & rda) | (rdx & rdp);

  always_ff @(posedge incp_clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      x_q       <= '0;
      p_q       <= sw;
      s_q       <= '0;
      pcarry_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      x_q       <= x_d;
      p_q       <= p_d;
      s_q       <= s_d;
      pcarry_q  <= pcarry_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef Q2_PSTACK_EN
  localparam int SPW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SPW:0] DEPTH_C = (SPW+1)'(STACK_DEPTH);

  logic [W-1:0]   stk_q [STACK_DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [SPW:0]   cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           push;

  // sp is a ring index; cnt tracks live entries so wrap can be flagged.
  assign push    = call & wrp;
  assign pop     = ret & ~call & ~wrp;
  assign stk_top = stk_q[sp_q - 1'b1];

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push) begin
      sp_d = sp_q + 1'b1;
      if (cnt_q == DEPTH_C) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (pop) begin
      sp_d = sp_q - 1'b1;
      if (cnt_q == '0) ovf_d = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge incp_clk or posedge rst) begin
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (push) stk_q[sp_q] <= p_q + 1'b1;
    end
  end

  assign stk_ovf = ovf_q;
`else
  logic unused_stk;

  assign pop        = 1'b0;
  assign stk_top    = '0;
  assign stk_ovf    = 1'b0;
  assign unused_stk = call ^ ret ^ (STACK_DEPTH == 0);
`endif

  assign aout       = a_q;
  assign xout       = x_q;
  assign pout       = p_q;
  assign sout       = s_q;
  assign xshift_out = x_q[W-1];
  assign pcarry     = pcarry_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_q2_word.sv
// tb/tb_q2_word.sv - scoreboard bench for q2_word against a per-cycle behavioural model
// Stack checks are compiled in when Q2_PSTACK_EN is defined.
module tb_q2_word;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw = '0, ain = '0, sin = '0;
  logic         dep = 0, wra = 0, rda = 0, wrx = 0, rdx = 0, xshift_in = 0;
  logic         incp = 0, wrp = 0, rdp = 0, wrs = 0, call = 0, ret = 0;
  logic [3:0]   xin_sel = '0;
  wire  [W-1:0] dbus, abus;
  logic [W-1:0] aout, xout, pout, sout;
  logic         xshift_out, pcarry, bus_err, stk_ovf;

  always #5 clk = ~clk;

  q2_word #(.W(W), .STACK_DEPTH(D)) dut (
    .incp_clk(clk), .rst(rst), .sw(sw), .dep(dep), .dbus(dbus), .abus(abus),
    .wra(wra), .rda(rda), .ain(ain), .wrx(wrx), .rdx(rdx), .xin_sel(xin_sel),
    .xshift_in(xshift_in), .incp(incp), .wrp(wrp), .rdp(rdp), .wrs(wrs), .sin(sin),
    .call(call), .ret(ret), .aout(aout), .xout(xout), .pout(pout), .sout(sout),
    .xshift_out(xshift_out), .pcarry(pcarry), .bus_err(bus_err), .stk_ovf(stk_ovf)
  );

  typedef struct {
    string    tag;
    bit [7:0] a, x, p, s;
    bit       pc, berr, ovf, xso;
    bit       dchk, achk;
    bit [7:0] dval, aval;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  bit [7:0] m_a, m_x, m_p, m_s;
  bit       m_pc, m_berr, m_ovf;
  bit [7:0] m_stk [D];
  int       m_sp, m_cnt;

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, ".a"}, aout, e.a);
      chk({e.tag, ".x"}, xout, e.x);
      chk({e.tag, ".p"}, pout, e.p);
      chk({e.tag, ".s"}, sout, e.s);
      chk({e.tag, ".pcarry"}, pcarry, e.pc);
      chk({e.tag, ".bus_err"}, bus_err, e.berr);
      chk({e.tag, ".stk_ovf"}, stk_ovf, e.ovf);
      chk({e.tag, ".xshift_out"}, xshift_out, e.xso);
      if (e.dchk) chk({e.tag, ".dbus"}, dbus, e.dval);
      if (e.achk) chk({e.tag, ".abus"}, abus, e.aval);
    end
  end

  function automatic exp_t snap(string tag);
    exp_t e;
    e.tag = tag; e.a = m_a; e.x = m_x; e.p = m_p; e.s = m_s;
    e.pc = m_pc; e.berr = m_berr; e.ovf = m_ovf; e.xso = m_x[7];
    e.dchk = dep || rda; e.dval = dep ? sw : m_a;
    e.achk = rdx || rdp; e.aval = rdx ? m_x : m_p;
    return e;
  endfunction

  function automatic void model_reset();
    m_a = 0; m_x = 0; m_s = 0; m_p = sw;
    m_pc = 0; m_berr = 0; m_ovf = 0; m_sp = 0; m_cnt = 0;
    for (int i = 0; i < D; i++) m_stk[i] = 0;
  endfunction

  // Apply current inputs for one edge: advance the model, queue the expectation.
  task automatic cycle(string tag);
    bit [7:0] dv, nx, np;
    bit       npc, push, pop;
    dv = dep ? sw : (rda ? m_a : 8'h00);
    nx = m_x;
    if (wrx) begin
      if (xin_sel == 4'b1000)      nx = 8'h00;
      else if (xin_sel == 4'b0100) nx = 8'((m_x << 1) | xshift_in);
      else if (xin_sel == 4'b0010) nx = m_p;
      else if (xin_sel == 4'b0001) nx = dv;
      else                         nx = 8'hFF;
    end
    push = 0; pop = 0;
`ifdef Q2_PSTACK_EN
    push = call && wrp;
    pop  = ret && !call && !wrp;
`endif
    np = m_p; npc = m_pc;
    if (wrp) begin
      np = m_x; npc = 0;
    end else if (pop) begin
      np = m_stk[(m_sp + D - 1) % D];
    end else if (incp) begin
      np = m_p + 8'd1; npc = (m_p == 8'hFF);
    end
    if (push) begin
      m_stk[m_sp] = m_p + 8'd1;
      m_sp = (m_sp + 1) % D;
      if (m_cnt == D) m_ovf = 1; else m_cnt++;
    end
    if (pop) begin
      m_sp = (m_sp + D - 1) % D;
      if (m_cnt == 0) m_ovf = 1; else m_cnt--;
    end
    if ((dep && rda) || (rdx && rdp)) m_berr = 1;
    if (wra) m_a = ain;
    if (wrs) m_s = sin;
    m_x = nx; m_p = np; m_pc = npc;
    exp_q.push_back(snap(tag));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    dep = 0; wra = 0; rda = 0; wrx = 0; rdx = 0; xshift_in = 0; xin_sel = 0;
    incp = 0; wrp = 0; rdp = 0; wrs = 0; call = 0; ret = 0;
  endtask

  task automatic do_reset(bit [7:0] v);
    idle();
    sw = v; rst = 1;
    model_reset();
    exp_q.push_back(snap("reset"));
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic set_x(bit [7:0] v);
    idle(); dep = 1; sw = v; wrx = 1; xin_sel = 4'b0001;
    cycle("set_x");
    idle();
  endtask

  task automatic set_p(bit [7:0] v);
    set_x(v); wrp = 1;
    cycle("set_p");
    idle();
  endtask

  initial begin
    @(negedge clk);
    do_reset(8'h5A);

    set_p(8'h30);
    incp = 1;
    cycle("inc_before_rst");
    #2;
    rst = 1; sw = 8'h77;
    model_reset();
    #1;
    chk("async_rst_p", pout, 8'h77);
    exp_q.push_back(snap("rst_mid_inc"));
    @(posedge clk);
    @(negedge clk);
    rst = 0; idle();

    set_p(8'hFE);
    incp = 1;
    cycle("inc_to_ff");
    cycle("inc_wrap");
    idle();
    set_x(8'h10);
    wrp = 1; incp = 1;
    cycle("wrp_over_incp");
    idle();

    set_x(8'h81);
    wrx = 1; xin_sel = 4'b0100; xshift_in = 1;
    cycle("shift");
    xin_sel = 4'b0110;
    cycle("xsel_bad");
    xin_sel = 4'b0000;
    cycle("xsel_zero");
    xin_sel = 4'b1000;
    cycle("xsel_clr");
    xin_sel = 4'b0010;
    cycle("xsel_p");
    idle();
    set_x(8'h3C);

    set_p(8'h22);
    set_x(8'h11);
    rdx = 1; rdp = 1;
    cycle("abus_conflict");
    idle();
    cycle("bus_err_sticky");
    wra = 1; ain = 8'hA5;
    cycle("load_a");
    idle(); dep = 1; rda = 1; sw = 8'h9C;
    cycle("dbus_conflict");
    idle(); rda = 1; wrs = 1; sin = 8'h6E;
    cycle("rda_wrs");
    idle();

`ifdef Q2_PSTACK_EN
    do_reset(8'h00);
    set_p(8'h20);
    set_x(8'h40);
    call = 1; wrp = 1;
    cycle("call");
    idle(); ret = 1;
    cycle("ret");
    idle(); call = 1;
    cycle("call_no_wrp");
    idle(); call = 1; ret = 1;
    cycle("call_ret_nowrp");
    for (int i = 0; i < 5; i++) begin
      set_x(8'h50 + 8'(i * 16));
      call = 1; wrp = 1;
      cycle("call_n");
      idle();
    end
    for (int i = 0; i < 5; i++) begin
      ret = 1;
      cycle("ret_n");
      idle();
    end
`else
    set_p(8'h44);
    call = 1;
    cycle("call_off");
    idle(); ret = 1;
    cycle("ret_off");
    idle(); call = 1; wrp = 1; set_x(8'h12);
    call = 1; wrp = 1;
    cycle("call_wrp_off");
    idle();
`endif

    do_reset(8'($urandom));
    for (int n = 0; n < 400; n++) begin
      int r;
      sw = 8'($urandom); ain = 8'($urandom); sin = 8'($urandom);
      dep = ($urandom_range(0, 7) == 0);
      rda = ($urandom_range(0, 3) == 0);
      rdx = ($urandom_range(0, 3) == 0);
      rdp = ($urandom_range(0, 5) == 0);
      wra = $urandom_range(0, 1); wrs = $urandom_range(0, 1);
      wrx = $urandom_range(0, 1); xshift_in = $urandom_range(0, 1);
      incp = ($urandom_range(0, 2) != 0);
      wrp = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 9);
      xin_sel = (r < 8) ? 4'(1 << (r % 4)) : 4'($urandom);
      if (wrx && xin_sel == 4'b0001 && !dep && !rda) rda = 1;
      call = ($urandom_range(0, 5) == 0);
      ret = ($urandom_range(0, 5) == 0) && (m_cnt > 0);
      if (n == 200) do_reset(8'($urandom));
      else cycle("rand");
    end
    idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
